noc_mem_responder: RTL and testbench
====================================

NOC_MEM_RESPONDER -- requirements
Module: noc_mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the flit data width.
REQ-002 The module SHALL have parameters MAX_ROUTERS_X and MAX_ROUTERS_Y, default 4 each, giving the mesh size; XW = $clog2(MAX_ROUTERS_X), YW = $clog2(MAX_ROUTERS_Y).
REQ-003 The module SHALL have parameters ROUTER_X and ROUTER_Y, default 0 each, giving this node's coordinates.
REQ-004 The module SHALL have parameter MAXIMUM_PACKAGES_NUMBER, default 5, giving the maximum payload flits per packet; LW = $clog2(MAXIMUM_PACKAGES_NUMBER).
REQ-005 The module SHALL have parameter MEM_DEPTH, default 16, giving the local word count; AW = $clog2(MEM_DEPTH).
REQ-006 Ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-007 Ports: req_tdata  in  DATA_WIDTH  request flit; req_tlast  in  1  last flit; req_tvalid  in  1; req_tready  out  1.
REQ-008 Ports: resp_tdata  out  DATA_WIDTH  response flit; resp_tlast  out  1; resp_tvalid  out  1; resp_tready  in  1.
REQ-009 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-010 The header flit SHALL be packed LSB-first as dst_x(XW), dst_y(YW), src_x(XW), src_y(YW), op(1: 0=write, 1=read), status(1), len(LW), addr(AW), with the remaining bits zero; default layout is [1:0] [3:2] [5:4] [7:6] [8] [9] [12:10] [16:13].
REQ-011 Transfers SHALL occur only when valid and ready are both high; resp_* SHALL stay stable while resp_tvalid=1 and resp_tready=0.
REQ-012 The FSM SHALL have states IDLE, WR_DATA, DROP, ACK, RD_HDR, RD_DATA.
REQ-013 In IDLE, req_tready SHALL be 1; an accepted header SHALL be latched.
REQ-014 A header whose dst differs from (ROUTER_X, ROUTER_Y) SHALL go to DROP, or stay in IDLE if tlast=1; DROP SHALL consume flits until tlast and produce no response.
REQ-015 A write with len>0 and tlast=0 SHALL go to WR_DATA, storing each payload word at (addr+k) mod MEM_DEPTH.
REQ-016 WR_DATA SHALL go to ACK on the len-th payload flit or on tlast, whichever comes first.
REQ-017 In WR_DATA, early tlast or missing tlast on the len-th flit SHALL set status=1; excess flits SHALL be discarded via DROP before ACK.
REQ-018 A write with len=0 or header tlast=1 SHALL go directly to ACK.
REQ-019 A read header SHALL go to RD_HDR; a read header without tlast SHALL set status=1 and drain the extra flits via DROP first.
REQ-020 Response headers SHALL carry dst=request src, src=(ROUTER_X, ROUTER_Y), and the same op and addr.
REQ-021 The ACK header SHALL have len=0 and tlast=1.
REQ-022 The RD_HDR header SHALL have len=request len and tlast=(len==0); RD_DATA SHALL then emit len words from (addr+k) mod MEM_DEPTH, with tlast on the final word.
REQ-023 req_tready SHALL be 0 in ACK, RD_HDR and RD_DATA.
REQ-024 Latency: resp_tvalid SHALL rise in the cycle after the accepting handshake of the header (read) or last consumed flit (write).
REQ-025 Response addresses SHALL use AW-bit wrap arithmetic.

Reset
REQ-026 While rst_n=0, the FSM SHALL be IDLE and resp_tvalid, resp_tlast, resp_tdata, req_tready and all counters SHALL be 0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A reset asserted mid-packet SHALL abandon the packet, with no partial response after release.

Configuration
REQ-029 With NOC_RESPONDER_PMU_EN defined, the module SHALL have outputs pmu_wr_cnt, pmu_rd_cnt, pmu_drop_cnt and pmu_err_cnt, each 16 bits, saturating at 16'hFFFF.
REQ-030 pmu_wr_cnt and pmu_rd_cnt SHALL increment on each final response flit; pmu_drop_cnt on each DROP entry for address mismatch; pmu_err_cnt on each status=1 response.
REQ-031 Without NOC_RESPONDER_PMU_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-032 Package noc_header_pkg SHALL hold the header field offsets/widths, the op constants and a header-build function shared with the router side.
REQ-033 The storage array SHALL be sub-module noc_resp_mem, with 1 write port, 1 asynchronous read port and MEM_DEPTH x DATA_WIDTH storage.

Verification (node (0,0), requester (2,1), defaults)
REQ-034 Write addr 3, len 2, data 0xA, 0xB -> one ACK flit: dst (2,1), len 0, status 0, tlast 1; then read addr 3, len 2 -> header + 0xA, 0xB, tlast on 0xB.
REQ-035 Write addr 15, len 3 with 1, 2, 3 -> read addr 0, len 2 returns 2, 3, confirming wrap.
REQ-036 Read len 4 with resp_tready low for 5 cycles mid-burst -> data held stable, 5 flits total, req_tready 0 throughout.
REQ-037 Header dst (1,0) with 2 payload flits -> all 3 consumed, no resp_tvalid, pmu_drop_cnt=1.
REQ-038 Write len 3 with tlast on the 2nd payload -> ACK status 1; only addr, addr+1 updated; pmu_err_cnt=1.
REQ-039 rst_n low during RD_DATA -> resp_tvalid 0 immediately; after release, a new request is served normally.

Source files
------------

// File: rtl/noc_header_pkg.sv
// Header layout shared by the responder and the router side: field offsets,
// op codes, FSM state codes and header build/extract helpers.
package noc_header_pkg;

    localparam int HDR_W = 64;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd1;
    localparam logic [2:0] S_DROP    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_RD_HDR  = 3'd4;
    localparam logic [2:0] S_RD_DATA = 3'd5;

    typedef enum logic [2:0] {
        F_DX, F_DY, F_SX, F_SY, F_OP, F_ST, F_LEN, F_ADDR
    } hdr_field_e;

    // Fields are packed LSB-first; op and status are one bit each.
    function automatic int hdr_off(hdr_field_e f, int xw, int yw, int lw);
        case (f)
            F_DX:    return 0;
            F_DY:    return xw;
            F_SX:    return xw + yw;
            F_SY:    return 2 * xw + yw;
            F_OP:    return 2 * xw + 2 * yw;
            F_ST:    return 2 * xw + 2 * yw + 1;
            F_LEN:   return 2 * xw + 2 * yw + 2;
            F_ADDR:  return 2 * xw + 2 * yw + 2 + lw;
            default: return 0;
        endcase
    endfunction

    function automatic logic [HDR_W-1:0] fmask(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [15:0] hdr_get(logic [HDR_W-1:0] h, int off, int w);
        return 16'((h >> off) & fmask(w));
    endfunction

    function automatic logic [HDR_W-1:0] hdr_build(
        int xw, int yw, int lw, int aw,
        logic [15:0] dx, logic [15:0] dy, logic [15:0] sx, logic [15:0] sy,
        logic op, logic st, logic [15:0] len, logic [15:0] addr);
        logic [HDR_W-1:0] h;
        h = (64'(dx) & fmask(xw))
          | ((64'(dy) & fmask(yw)) << hdr_off(F_DY, xw, yw, lw))
          | ((64'(sx) & fmask(xw)) << hdr_off(F_SX, xw, yw, lw))
          | ((64'(sy) & fmask(yw)) << hdr_off(F_SY, xw, yw, lw))
          | (64'(op) << hdr_off(F_OP, xw, yw, lw))
          | (64'(st) << hdr_off(F_ST, xw, yw, lw))
          | ((64'(len) & fmask(lw)) << hdr_off(F_LEN, xw, yw, lw))
          | ((64'(addr) & fmask(aw)) << hdr_off(F_ADDR, xw, yw, lw));
        return h;
    endfunction

    function automatic logic [15:0] sat_inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/noc_resp_mem.sv
// Local word store: one synchronous write port, one asynchronous read port, no reset.
module noc_resp_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/noc_mem_responder.sv
// NoC memory responder: serves write/read packets addressed to this node.
// Optional performance counters are built when NOC_RESPONDER_PMU_EN is defined.
module noc_mem_responder
    import noc_header_pkg::*;
#(
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5,
    parameter int MEM_DEPTH               = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] req_tdata,
    input  logic                  req_tlast,
    input  logic                  req_tvalid,
    output logic                  req_tready,
    output logic [DATA_WIDTH-1:0] resp_tdata,
    output logic                  resp_tlast,
    output logic                  resp_tvalid,
    input  logic                  resp_tready
`ifdef NOC_RESPONDER_PMU_EN
    ,
    output logic [15:0]           pmu_wr_cnt,
    output logic [15:0]           pmu_rd_cnt,
    output logic [15:0]           pmu_drop_cnt,
    output logic [15:0]           pmu_err_cnt
`endif
);

    localparam int XW = $clog2(MAX_ROUTERS_X);
    localparam int YW = $clog2(MAX_ROUTERS_Y);
    localparam int LW = $clog2(MAXIMUM_PACKAGES_NUMBER);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [2:0]            state_q, state_d, drop_ret_q, drop_ret_d;
    logic [XW-1:0]         src_x_q, src_x_d;
    logic [YW-1:0]         src_y_q, src_y_d;
    logic                  op_q, op_d, status_q, status_d;
    logic [LW-1:0]         len_q, len_d, cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  req_tready_q, req_tready_d;
    logic                  resp_tvalid_q, resp_tvalid_d;
    logic                  resp_tlast_q, resp_tlast_d;
    logic [DATA_WIDTH-1:0] resp_tdata_q, resp_tdata_d;

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr, mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [HDR_W-1:0]      req_hdr;
    logic                  req_fire, resp_fire, hdr_local, last_word;
    logic [LW:0]           cnt_inc;

    assign req_fire  = req_tvalid && req_tready_q;
    assign resp_fire = resp_tvalid_q && resp_tready;
    assign req_hdr   = HDR_W'(req_tdata);
    assign hdr_local = (XW'(hdr_get(req_hdr, hdr_off(F_DX, XW, YW, LW), XW)) == XW'(ROUTER_X))
                    && (YW'(hdr_get(req_hdr, hdr_off(F_DY, XW, YW, LW), YW)) == YW'(ROUTER_Y));
    assign cnt_inc   = (LW+1)'(cnt_q) + (LW+1)'(1);
    assign last_word = (cnt_inc == (LW+1)'(len_q));

    noc_resp_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (req_tdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        drop_ret_d = drop_ret_q;
        src_x_d    = src_x_q;
        src_y_d    = src_y_q;
        op_d       = op_q;
        status_d   = status_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q + AW'(cnt_q);

        case (state_q)
            S_IDLE: if (req_fire) begin
                src_x_d  = XW'(hdr_get(req_hdr, hdr_off(F_SX, XW, YW, LW), XW));
                src_y_d  = YW'(hdr_get(req_hdr, hdr_off(F_SY, XW, YW, LW), YW));
                op_d     = 1'(hdr_get(req_hdr, hdr_off(F_OP, XW, YW, LW), 1));
                len_d    = LW'(hdr_get(req_hdr, hdr_off(F_LEN, XW, YW, LW), LW));
                addr_d   = AW'(hdr_get(req_hdr, hdr_off(F_ADDR, XW, YW, LW), AW));
                status_d = 1'b0;
                cnt_d    = '0;
                if (!hdr_local) begin
                    if (!req_tlast) begin
                        state_d    = S_DROP;
                        drop_ret_d = S_IDLE;
                    end
                end else if (op_d == OP_READ) begin
                    if (req_tlast) begin
                        state_d = S_RD_HDR;
                    end else begin
                        status_d   = 1'b1;
                        state_d    = S_DROP;
                        drop_ret_d = S_RD_HDR;
                    end
                end else if (len_d == '0 || req_tlast) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: if (req_fire) begin
                mem_we = 1'b1;
                cnt_d  = cnt_inc[LW-1:0];
                if (last_word) begin
                    if (req_tlast) begin
                        state_d = S_ACK;
                    end else begin
                        status_d   = 1'b1;
                        state_d    = S_DROP;
                        drop_ret_d = S_ACK;
                    end
                end else if (req_tlast) begin
                    status_d = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_DROP: if (req_fire && req_tlast) state_d = drop_ret_q;
            S_ACK: if (resp_fire) state_d = S_IDLE;
            S_RD_HDR: if (resp_fire) begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? S_IDLE : S_RD_DATA;
            end
            S_RD_DATA: if (resp_fire) begin
                if (last_word) state_d = S_IDLE;
                else           cnt_d   = cnt_inc[LW-1:0];
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they hold while stalled.
        mem_raddr     = addr_d + AW'(cnt_d);
        req_tready_d  = (state_d == S_IDLE) || (state_d == S_WR_DATA) || (state_d == S_DROP);
        resp_tvalid_d = (state_d == S_ACK) || (state_d == S_RD_HDR) || (state_d == S_RD_DATA);
        resp_tlast_d  = 1'b0;
        resp_tdata_d  = '0;
        case (state_d)
            S_ACK: begin
                resp_tdata_d = DATA_WIDTH'(hdr_build(XW, YW, LW, AW, 16'(src_x_d), 16'(src_y_d),
                    16'(ROUTER_X), 16'(ROUTER_Y), op_d, status_d, 16'd0, 16'(addr_d)));
                resp_tlast_d = 1'b1;
            end
            S_RD_HDR: begin
                resp_tdata_d = DATA_WIDTH'(hdr_build(XW, YW, LW, AW, 16'(src_x_d), 16'(src_y_d),
                    16'(ROUTER_X), 16'(ROUTER_Y), op_d, status_d, 16'(len_d), 16'(addr_d)));
                resp_tlast_d = (len_d == '0);
            end
            S_RD_DATA: begin
                resp_tdata_d = mem_rdata;
                resp_tlast_d = ((LW+1)'(cnt_d) + (LW+1)'(1)) == (LW+1)'(len_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            drop_ret_q    <= S_IDLE;
            src_x_q       <= '0;
            src_y_q       <= '0;
            op_q          <= 1'b0;
            status_q      <= 1'b0;
            len_q         <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            req_tready_q  <= 1'b0;
            resp_tvalid_q <= 1'b0;
            resp_tlast_q  <= 1'b0;
            resp_tdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            drop_ret_q    <= drop_ret_d;
            src_x_q       <= src_x_d;
            src_y_q       <= src_y_d;
            op_q          <= op_d;
            status_q      <= status_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            req_tready_q  <= req_tready_d;
            resp_tvalid_q <= resp_tvalid_d;
            resp_tlast_q  <= resp_tlast_d;
            resp_tdata_q  <= resp_tdata_d;
        end
    end

    assign req_tready  = req_tready_q;
    assign resp_tvalid = resp_tvalid_q;
    assign resp_tlast  = resp_tlast_q;
    assign resp_tdata  = resp_tdata_q;

`ifdef NOC_RESPONDER_PMU_EN
    logic [15:0] pmu_wr_q, pmu_wr_d, pmu_rd_q, pmu_rd_d;
    logic [15:0] pmu_drop_q, pmu_drop_d, pmu_err_q, pmu_err_d;
    logic        drop_mismatch;

    assign drop_mismatch = (state_q == S_IDLE) && req_fire && !hdr_local && !req_tlast;

    // A response is counted once, on its final flit.
    always_comb begin
        pmu_wr_d   = pmu_wr_q;
        pmu_rd_d   = pmu_rd_q;
        pmu_drop_d = pmu_drop_q;
        pmu_err_d  = pmu_err_q;
        if (resp_fire && resp_tlast_q) begin
            if (op_q == OP_WRITE) pmu_wr_d = sat_inc16(pmu_wr_q);
            else                  pmu_rd_d = sat_inc16(pmu_rd_q);
            if (status_q)         pmu_err_d = sat_inc16(pmu_err_q);
        end
        if (drop_mismatch) pmu_drop_d = sat_inc16(pmu_drop_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmu_wr_q   <= '0;
            pmu_rd_q   <= '0;
            pmu_drop_q <= '0;
            pmu_err_q  <= '0;
        end else begin
            pmu_wr_q   <= pmu_wr_d;
            pmu_rd_q   <= pmu_rd_d;
            pmu_drop_q <= pmu_drop_d;
            pmu_err_q  <= pmu_err_d;
        end
    end

    assign pmu_wr_cnt   = pmu_wr_q;
    assign pmu_rd_cnt   = pmu_rd_q;
    assign pmu_drop_cnt = pmu_drop_q;
    assign pmu_err_cnt  = pmu_err_q;
`endif

endmodule

// File: tb/tb_noc_mem_responder.sv
// Scoreboard bench for noc_mem_responder at node (0,0): a packet-level model
// predicts every response flit; a monitor checks each response handshake.
module tb_noc_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_tdata;
    logic        req_tlast, req_tvalid, req_tready;
    logic [31:0] resp_tdata;
    logic        resp_tlast, resp_tvalid, resp_tready;
`ifdef NOC_RESPONDER_PMU_EN
    logic [15:0] pmu_wr_cnt, pmu_rd_cnt, pmu_drop_cnt, pmu_err_cnt;
`endif

    always #5 clk = ~clk;

    noc_mem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_tdata   (req_tdata),
        .req_tlast   (req_tlast),
        .req_tvalid  (req_tvalid),
        .req_tready  (req_tready),
        .resp_tdata  (resp_tdata),
        .resp_tlast  (resp_tlast),
        .resp_tvalid (resp_tvalid),
        .resp_tready (resp_tready)
`ifdef NOC_RESPONDER_PMU_EN
        ,
        .pmu_wr_cnt   (pmu_wr_cnt),
        .pmu_rd_cnt   (pmu_rd_cnt),
        .pmu_drop_cnt (pmu_drop_cnt),
        .pmu_err_cnt  (pmu_err_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mem_m[16];
    int          m_wr = 0, m_rd = 0, m_drop = 0, m_err = 0;
    logic [31:0] pkt[16];
    int          pkt_n;
    bit          ready_manual = 1'b0;
    bit          ready_val = 1'b1;

    function automatic logic [31:0] mk_hdr(int dx, int dy, int sx, int sy, int op, int st, int len, int addr);
        return {15'd0, 4'(addr), 3'(len), 1'(st), 1'(op), 2'(sy), 2'(sx), 2'(dy), 2'(dx)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Packet-level reference: what the node must answer for pkt[0..pkt_n-1].
    task automatic model_pkt();
        logic [31:0] h;
        int dx, dy, sx, sy, op, len, addr, np, n, st;
        h    = pkt[0];
        dx   = int'(h[1:0]);
        dy   = int'(h[3:2]);
        sx   = int'(h[5:4]);
        sy   = int'(h[7:6]);
        op   = int'(h[8]);
        len  = int'(h[12:10]);
        addr = int'(h[16:13]);
        np   = pkt_n - 1;
        if (dx != 0 || dy != 0) begin
            if (np > 0) m_drop++;
        end else if (op == 1) begin
            st = (np > 0) ? 1 : 0;
            exp_q.push_back({(len == 0), mk_hdr(sx, sy, 0, 0, 1, st, len, addr)});
            for (int k = 0; k < len; k++)
                exp_q.push_back({(k == len - 1), mem_m[(addr + k) % 16]});
            m_rd++;
            if (st != 0) m_err++;
        end else begin
            st = 0;
            if (len != 0 && np > 0) begin
                n = (np < len) ? np : len;
                for (int k = 0; k < n; k++) mem_m[(addr + k) % 16] = pkt[k + 1];
                st = (np != len) ? 1 : 0;
            end
            exp_q.push_back({1'b1, mk_hdr(sx, sy, 0, 0, 0, st, 0, addr)});
            m_wr++;
            if (st != 0) m_err++;
        end
    endtask

    task automatic send_flit(input logic [31:0] d, input logic l);
        int t;
        t = 0;
        req_tdata  = d;
        req_tlast  = l;
        req_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (req_tready) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL req_accept_timeout flits not accepted after %0d cycles", t);
                summary();
            end
        end
        @(posedge clk);
        #1;
        req_tvalid = 1'b0;
        req_tlast  = 1'b0;
        req_tdata  = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt();
        model_pkt();
        for (int i = 0; i < pkt_n; i++) send_flit(pkt[i], (i == pkt_n - 1));
    endtask

    task automatic fill_payload(input int np);
        for (int k = 1; k <= np; k++) pkt[k] = $urandom;
        pkt_n = np + 1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || resp_tvalid) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_queue_le(input int n);
        int t;
        t = 0;
        while (exp_q.size() > n && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("queue_progress_timeout", 64'(t >= 1000), 64'(0));
    endtask

`ifdef NOC_RESPONDER_PMU_EN
    task automatic check_pmu();
        check("pmu_wr_cnt", 64'(pmu_wr_cnt), 64'(m_wr));
        check("pmu_rd_cnt", 64'(pmu_rd_cnt), 64'(m_rd));
        check("pmu_drop_cnt", 64'(pmu_drop_cnt), 64'(m_drop));
        check("pmu_err_cnt", 64'(pmu_err_cnt), 64'(m_err));
    endtask
`endif

    initial begin
        resp_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            resp_tready = ready_manual ? ready_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every response handshake pops one expected flit.
    initial begin
        logic        prev_stall;
        logic [32:0] prev_flit;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("resp_hold", 64'({resp_tvalid, resp_tlast, resp_tdata}), 64'({1'b1, prev_flit}));
                if (resp_tvalid) check("req_tready_during_resp", 64'(req_tready), 64'(0));
                if (resp_tvalid && resp_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected got %h expected no flit", {resp_tlast, resp_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_flit", 64'({resp_tlast, resp_tdata}), 64'(e));
                    end
                end
                prev_stall = resp_tvalid && !resp_tready;
                prev_flit  = {resp_tlast, resp_tdata};
            end
        end
    end

    initial begin
        int dx, dy, op, len, addr, np;
        rst_n      = 1'b0;
        req_tvalid = 1'b0;
        req_tlast  = 1'b0;
        req_tdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_tvalid", 64'(resp_tvalid), 64'(0));
        check("rst_resp_tlast", 64'(resp_tlast), 64'(0));
        check("rst_resp_tdata", 64'(resp_tdata), 64'(0));
        check("rst_req_tready", 64'(req_tready), 64'(0));
`ifdef NOC_RESPONDER_PMU_EN
        check_pmu();
`endif
        rst_n = 1'b1;

        // Give every memory word a known value.
        for (int a = 0; a < 16; a += 5) begin
            pkt[0] = mk_hdr(0, 0, 2, 1, 0, 0, 5, a);
            fill_payload(5);
            send_pkt();
        end
        wait_drain();

        // Write then read back two words.
        pkt[0] = mk_hdr(0, 0, 2, 1, 0, 0, 2, 3);
        pkt[1] = 32'hA;
        pkt[2] = 32'hB;
        pkt_n  = 3;
        send_pkt();
        pkt[0] = mk_hdr(0, 0, 2, 1, 1, 0, 2, 3);
        pkt_n  = 1;
        send_pkt();
        wait_drain();

        // Address wrap across the top of memory.
        pkt[0] = mk_hdr(0, 0, 2, 1, 0, 0, 3, 15);
        pkt[1] = 32'd1;
        pkt[2] = 32'd2;
        pkt[3] = 32'd3;
        pkt_n  = 4;
        send_pkt();
        pkt[0] = mk_hdr(0, 0, 2, 1, 1, 0, 2, 0);
        pkt_n  = 1;
        send_pkt();
        wait_drain();

        // Foreign destination is dropped silently.
        pkt[0] = mk_hdr(1, 0, 2, 1, 0, 0, 2, 5);
        fill_payload(2);
        send_pkt();
        // Early tlast on a write, then read the range back.
        pkt[0] = mk_hdr(0, 0, 2, 1, 0, 0, 3, 8);
        fill_payload(2);
        send_pkt();
        pkt[0] = mk_hdr(0, 0, 2, 1, 1, 0, 3, 8);
        pkt_n  = 1;
        send_pkt();
        wait_drain();
`ifdef NOC_RESPONDER_PMU_EN
        check_pmu();
`endif

        // Back-pressure in the middle of a read burst.
        ready_manual = 1'b1;
        ready_val    = 1'b1;
        pkt[0] = mk_hdr(0, 0, 2, 1, 1, 0, 4, 6);
        pkt_n  = 1;
        send_pkt();
        wait_queue_le(3);
        ready_val = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ready_val = 1'b1;
        wait_drain();
        ready_manual = 1'b0;

        for (int p = 0; p < 40; p++) begin
            dx = 0;
            dy = 0;
            if ($urandom_range(0, 6) == 0) begin
                dx = $urandom_range(0, 3);
                dy = $urandom_range(1, 3);
            end
            op   = $urandom_range(0, 1);
            len  = $urandom_range(0, 5);
            addr = $urandom_range(0, 15);
            if (dx != 0 || dy != 0)  np = $urandom_range(0, 3);
            else if (op == 1)        np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            else if (len == 0)       np = 0;
            else                     np = $urandom_range(1, len + 2);
            pkt[0] = mk_hdr(dx, dy, $urandom_range(0, 3), $urandom_range(0, 3), op, 0, len, addr);
            fill_payload(np);
            send_pkt();
        end
        wait_drain();
`ifdef NOC_RESPONDER_PMU_EN
        check_pmu();
`endif

        // Reset in the middle of a read data burst.
        ready_manual = 1'b1;
        ready_val    = 1'b1;
        pkt[0] = mk_hdr(0, 0, 3, 2, 1, 0, 4, 12);
        pkt_n  = 1;
        send_pkt();
        wait_queue_le(3);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_tvalid", 64'(resp_tvalid), 64'(0));
        check("midrst_req_tready", 64'(req_tready), 64'(0));
        exp_q.delete();
        m_wr   = 0;
        m_rd   = 0;
        m_drop = 0;
        m_err  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        ready_manual = 1'b0;
        pkt[0] = mk_hdr(0, 0, 1, 3, 0, 0, 2, 12);
        fill_payload(2);
        send_pkt();
        pkt[0] = mk_hdr(0, 0, 1, 3, 1, 0, 3, 11);
        pkt_n  = 1;
        send_pkt();
        wait_drain();
`ifdef NOC_RESPONDER_PMU_EN
        check_pmu();
`endif

        summary();
    end

endmodule
